// File: rtl/i2s_clkgen.sv
// I2S bit-clock / word-select generator with a one-cycle falling-edge strobe.
// Optional frame counter output enabled by defining I2S_CLKGEN_FRMCNT_EN.
module i2s_clkgen (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [15:0] div_i,
    input  logic [1:0]  chl_i,
    input  logic        pol_i,
    output logic        i2s_sck_o,
    output logic        i2s_sck_trg_o,
    output logic        i2s_ws_o,
`ifdef I2S_CLKGEN_FRMCNT_EN
    output logic [15:0] frm_cnt_o,
`endif
    output logic        busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q;
    logic [15:0] div_q;
    logic [15:0] cnt_q;
    logic        sck_q;
    logic        trg_q;
    logic        ws_q;
    logic [4:0]  bit_q;
    logic [1:0]  chl_q;

    logic        idle_w;
    logic        wrap_w;
    logic        fall_w;
    logic        chwrap_w;
    logic [4:0]  bit_last_w;

    // Decode the per-cycle events: forced idle, divider wrap, SCK fall, channel end
    always_comb begin
        idle_w     = (state_q == ST_IDLE) || !en_i;
        wrap_w     = (cnt_q == div_q);
        fall_w     = !idle_w && wrap_w && sck_q;
        bit_last_w = {chl_q, 3'b111};
        chwrap_w   = fall_w && (bit_q == bit_last_w);
    end

    // Run/idle state; a low enable always wins over any pending SCK event
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= ST_IDLE;
        else if (en_i)
            state_q <= ST_RUN;
        else
            state_q <= ST_IDLE;
    end

    // Divider: count to div_q, toggle SCK; div_q reloads only when idle or on a fall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
            trg_q <= 1'b0;
            div_q <= '0;
        end else if (idle_w) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
            trg_q <= 1'b0;
            div_q <= div_i;
        end else if (wrap_w) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
            trg_q <= sck_q;
            if (sck_q)
                div_q <= div_i;
        end else begin
            cnt_q <= cnt_q + 16'd1;
            trg_q <= 1'b0;
        end
    end

    // Bit counter and word select, advanced on SCK falls; channel length latched per channel
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_q <= '0;
            ws_q  <= 1'b0;
            chl_q <= '0;
        end else if (idle_w) begin
            bit_q <= '0;
            ws_q  <= 1'b0;
            chl_q <= chl_i;
        end else if (chwrap_w) begin
            bit_q <= '0;
            ws_q  <= ~ws_q;
            chl_q <= chl_i;
        end else if (fall_w) begin
            bit_q <= bit_q + 5'd1;
        end
    end

`ifdef I2S_CLKGEN_FRMCNT_EN
    logic [15:0] frm_q;

    // Completed stereo frames: counted when WS returns from right to left
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            frm_q <= '0;
        else if (idle_w)
            frm_q <= '0;
        else if (chwrap_w && ws_q)
            frm_q <= frm_q + 16'd1;
    end

    assign frm_cnt_o = frm_q;
`endif

    assign i2s_sck_o     = sck_q;
    assign i2s_sck_trg_o = trg_q;
    assign i2s_ws_o      = ws_q ^ pol_i;
    assign busy_o        = (state_q == ST_RUN);

endmodule

// File: tb/tb_i2s_clkgen.sv
// Scoreboard bench for i2s_clkgen: expected SCK falls (time, WS) are queued
// from an arithmetic model; a monitor pops one entry per observed trg pulse.
module tb_i2s_clkgen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i  = 1'b0;
    logic [15:0] div_i = '0;
    logic [1:0]  chl_i = '0;
    logic        pol_i = 1'b0;
    logic        i2s_sck_o;
    logic        i2s_sck_trg_o;
    logic        i2s_ws_o;
    logic        busy_o;
`ifdef I2S_CLKGEN_FRMCNT_EN
    logic [15:0] frm_cnt_o;
`endif

    i2s_clkgen dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .div_i         (div_i),
        .chl_i         (chl_i),
        .pol_i         (pol_i),
        .i2s_sck_o     (i2s_sck_o),
        .i2s_sck_trg_o (i2s_sck_trg_o),
        .i2s_ws_o      (i2s_ws_o),
`ifdef I2S_CLKGEN_FRMCNT_EN
        .frm_cnt_o     (frm_cnt_o),
`endif
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int   t;
        logic ws;
    } ev_t;

    ev_t q[$];
    int  cyc   = 0;
    int  n_chk = 0;
    int  n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // WS level after the k-th SCK fall: walk channel boundaries; channels
    // starting at or before fall m use length la, later ones lb.
    function automatic logic ws_after(input int k, input int la, input int lb,
                                      input int m, input logic pol);
        int s;
        int n;
        int len;
        s = 0;
        n = 0;
        len = la;
        while (s + len <= k) begin
            s = s + len;
            n++;
            len = (s <= m) ? la : lb;
        end
        return pol ^ n[0];
    endfunction

    // Monitor: every trg pulse must match the head of the expectation queue
    always @(negedge clk_i) begin
        if (i2s_sck_trg_o) begin
            if (q.size() == 0) begin
                chk("unexpected_trg", 1, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("trg_time", cyc, e.t);
                chk("trg_ws", int'(i2s_ws_o), int'(e.ws));
                chk("trg_sck_low", int'(i2s_sck_o), 0);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk_i);
    endtask

    // One enabled run of K falls with fixed div/pol; chl may change after fall m.
    // Ends h cycles after fall K either by dropping en_i or by a reset pulse.
    task automatic run(input int d, input int ca, input int cb, input int m,
                       input logic pol, input int k_n, input int h,
                       input bit do_rst, input int frm_exp);
        int c;
        int la;
        int lb;
        la = (ca + 1) * 8;
        lb = (cb + 1) * 8;
        div_i = 16'(d);
        chl_i = 2'(ca);
        pol_i = pol;
        en_i  = 1'b1;
        c = cyc;
        for (int k = 1; k <= k_n; k++) begin
            ev_t e;
            e.t  = c + 1 + 2 * k * (d + 1);
            e.ws = ws_after(k, la, lb, m, pol);
            q.push_back(e);
        end
        wait_cyc(c + 1);
        chk("busy_run", int'(busy_o), 1);
        wait_cyc(c + d + 1);
        chk("sck_before_rise", int'(i2s_sck_o), 0);
        wait_cyc(c + d + 2);
        chk("sck_first_rise", int'(i2s_sck_o), 1);
        chk("ws_first_left", int'(i2s_ws_o), int'(pol));
        if (m > 0) begin
            wait_cyc(c + 1 + 2 * m * (d + 1));
            chl_i = 2'(cb);
        end
        wait_cyc(c + 1 + 2 * k_n * (d + 1));
`ifdef I2S_CLKGEN_FRMCNT_EN
        if (frm_exp >= 0)
            chk("frm_cnt", int'(frm_cnt_o), frm_exp);
`endif
        wait_cyc(c + 1 + 2 * k_n * (d + 1) + h);
        if (do_rst) begin
            #2;
            rst_i = 1'b1;
            #1;
            chk("rst_sck", int'(i2s_sck_o), 0);
            chk("rst_trg", int'(i2s_sck_trg_o), 0);
            chk("rst_busy", int'(busy_o), 0);
            chk("rst_ws", int'(i2s_ws_o), int'(pol));
            chk("rst_q_empty", q.size(), 0);
            @(negedge clk_i);
            @(negedge clk_i);
            rst_i = 1'b0;
        end else begin
            en_i = 1'b0;
            @(negedge clk_i);
            #1;
            chk("off_sck", int'(i2s_sck_o), 0);
            chk("off_trg", int'(i2s_sck_trg_o), 0);
            chk("off_busy", int'(busy_o), 0);
            chk("off_ws", int'(i2s_ws_o), int'(pol));
            chk("off_q_empty", q.size(), 0);
            repeat (3) @(negedge clk_i);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("reset_sck", int'(i2s_sck_o), 0);
        chk("reset_trg", int'(i2s_sck_trg_o), 0);
        chk("reset_ws", int'(i2s_ws_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("idle_busy", int'(busy_o), 0);

        run(3, 0, 0, 0, 1'b0, 20, 2, 1'b0, -1);
        run(0, 3, 3, 0, 1'b1, 70, 1, 1'b0, -1);
        run(1, 0, 1, 3, 1'b0, 40, 0, 1'b0, -1);
        run(2, 1, 1, 0, 1'b0, 5, 4, 1'b0, -1);
        run(5, 2, 2, 0, 1'b1, 7, 3, 1'b1, -1);
        run(5, 2, 2, 0, 1'b1, 10, 0, 1'b0, -1);
        run(0, 0, 0, 0, 1'b0, 48, 0, 1'b0, 3);

        for (int r = 0; r < 20; r++) begin
            int d;
            int ca;
            int cb;
            int m;
            int kn;
            int h;
            d  = int'($urandom_range(0, 4));
            ca = int'($urandom_range(0, 3));
            kn = int'($urandom_range(1, 60));
            h  = int'($urandom_range(0, 2 * d + 1));
            m  = 0;
            cb = ca;
            if (kn > 2 && $urandom_range(0, 1) == 1) begin
                m  = int'($urandom_range(1, kn - 1));
                cb = int'($urandom_range(0, 3));
            end
            run(d, ca, cb, m, 1'($urandom_range(0, 1)), kn, h,
                ($urandom_range(0, 3) == 0), -1);
            if (en_i)
                run(d, cb, cb, 0, pol_i, 4, 0, 1'b0, -1);
        end

        repeat (5) @(negedge clk_i);
        chk("final_q_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: got cyc %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2s_clkgen.md
I2S_CLKGEN -- requirements
Module: i2s_clkgen

Interface
REQ-001 SHALL have port clk_i, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port en_i, input, 1, generator enable; low forces idle.
REQ-004 SHALL have port div_i, input, 16, half-period of SCK in clk_i cycles minus one.
REQ-005 SHALL have port chl_i, input, 2, channel length: 0=8, 1=16, 2=24, 3=32 SCK cycles.
REQ-006 SHALL have port pol_i, input, 1, WS polarity: 0 = left channel while WS low, 1 = inverted.
REQ-007 SHALL have port i2s_sck_o, output, 1, bit clock to the I2S core and pad.
REQ-008 SHALL have port i2s_sck_trg_o, output, 1, one-clk_i pulse marking each SCK falling edge; drives the core's i2s_sck_trg_i.
REQ-009 SHALL have port i2s_ws_o, output, 1, word select, changes only on SCK falling edges.
REQ-010 SHALL have port busy_o, input-independent output, 1, high while generator is running.

Function
REQ-011 Divider counter SHALL count 0..div_q while en_i high; at div_q it SHALL wrap to 0 and toggle sck_q, giving SCK period 2*(div_q+1) clk_i cycles.
REQ-012 div_q SHALL load div_i when idle and at each SCK falling edge; div_i changes mid-half-period SHALL NOT shorten the current half-period.
REQ-013 div_i=0 SHALL give SCK = clk_i/2 (toggle every cycle).
REQ-014 i2s_sck_trg_o SHALL be high for exactly the one clk_i cycle in which sck_q transitions 1->0, registered, no combinational path from inputs.
REQ-015 Bit counter SHALL increment on each SCK falling edge, range 0..chlen-1, chlen per chl_i; at chlen-1 it SHALL wrap to 0 and toggle ws_q on that same falling edge.
REQ-016 chl_i SHALL be latched into chl_q only when the bit counter wraps or when idle; mid-channel changes take effect at the next channel boundary.
REQ-017 i2s_ws_o SHALL equal ws_q XOR pol_i.
REQ-018 FSM states: IDLE, RUN. IDLE->RUN when en_i high; RUN->IDLE when en_i low, taking effect the next clk_i edge regardless of SCK phase.
REQ-019 Entering IDLE SHALL clear divider, bit counter, sck_q, ws_q and trg synchronously; no trailing trg pulse.
REQ-020 First SCK rising edge after IDLE->RUN SHALL occur div_q+1 clk_i cycles after en_i is sampled high; first channel is left (ws_q=0).
REQ-021 busy_o SHALL be high exactly when state is RUN.
REQ-022 Simultaneous divider wrap and en_i falling SHALL resolve to IDLE (disable wins).

Reset
REQ-023 rst_i high SHALL asynchronously set state IDLE, i2s_sck_o=0, i2s_sck_trg_o=0, ws_q=0, busy_o=0, all counters 0, div_q=0, chl_q=0.
REQ-024 Reset asserted mid-frame SHALL abort immediately; after release, operation restarts per REQ-020 only once en_i is high.

Configuration
REQ-025 Macro I2S_CLKGEN_FRMCNT_EN defined SHALL add output frm_cnt_o (16 bits), incremented on every ws_q 1->0 transition (completed stereo frame), wrapping 0xFFFF->0, cleared by reset and in IDLE.
REQ-026 Macro undefined SHALL omit the port and its counter entirely; all other behaviour identical.

Verification
REQ-027 div_i=3, chl_i=0, en_i=1 -> SCK period 8 clk_i cycles, WS toggles every 8 SCK falls, trg pulse width 1 clk_i.
REQ-028 div_i=0, chl_i=3, pol_i=1 -> SCK toggles each clk_i, i2s_ws_o starts high, toggles every 32 SCK periods.
REQ-029 chl_i changed 0->1 at bit 3 of a channel -> current channel still 8 bits, next channel 16 bits.
REQ-030 en_i dropped at SCK high mid-channel -> next cycle sck=0, ws=pol_i, busy_o=0, no trg pulse.
REQ-031 rst_i pulsed during RUN with div_i=5 -> all outputs 0 asynchronously; with en_i held, first SCK rise 6 cycles after release.
REQ-032 With I2S_CLKGEN_FRMCNT_EN, div_i=0, chl_i=0, run 3 frames -> frm_cnt_o=3; without macro build compiles with no frm_cnt_o.
